fwd_sel_ctrl: RTL and testbench

- Produces the 3-bit select codes that drive the two 8x32 EX-stage operand multiplexers in the 5-stage pipelined MIPS core.
- Keeps its own shadow of destination-register state for the EX, MEM and WB stages.
- Compares that state against the ID-stage source registers and outputs a select code for each EX operand, registered so it lines up with the operand arriving in EX.
- Detects load-use hazards, raises a stall and inserts a bubble.

---
 rtl/fwd_sel_ctrl_pkg.sv | 62 ++++++
 rtl/fwd_sel_ctrl_match.sv | 29 ++
 rtl/fwd_sel_ctrl.sv | 134 +++++++++++++
 tb/tb_fwd_sel_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_sel_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_sel_ctrl_pkg
//   Shared definitions for the EX-stage operand forwarding controller and the
//   8x32 operand multiplexers it steers. The select-code constants here are
//   the single source of truth: the mux decodes exactly these values.
//
//   Contents:
//     REG_W / SEL_W      register-index and select-code widths
//     SEL_RF/MEM/WB      operand-mux select codes (3..7 reserved)
//     stage_t            per-stage destination-register shadow
//     ST_EX/MEM/WB       indices of the tracked stages
//     pickSel()          nearest-stage-first forwarding priority
// ---------------------------------------------------------------------------
package fwd_sel_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int SEL_W = 3;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [SEL_W-1:0] sel_t;

  // Operand-mux select codes; values 3..7 are reserved and never produced.
  localparam sel_t SEL_RF  = sel_t'(0);
  localparam sel_t SEL_MEM = sel_t'(1);
  localparam sel_t SEL_WB  = sel_t'(2);

  // Shadow of the writer information carried by an instruction in one stage.
  typedef struct packed {
    logic     wreg;
    reg_idx_t wn;
    logic     m2reg;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  localparam int NUM_STAGES = 3;
  localparam int ST_EX      = 0;
  localparam int ST_MEM     = 1;
  localparam int ST_WB      = 2;

  // Forwarding priority, nearest producer first. A non-load producer one
  // stage ahead will be in MEM when the consumer reaches EX; a producer two
  // stages ahead will be in WB. A producer three stages ahead is already
  // being written into the register file, whose write-through covers it.
  // A load one stage ahead never reaches here: it stalls and bubbles instead.
  function automatic sel_t pickSel(input logic hitEx,
                                   input logic exIsLoad,
                                   input logic hitMem,
                                   input logic hitWb);
    sel_t sel;
    sel = SEL_RF;
    if (hitEx && !exIsLoad) begin
      sel = SEL_MEM;
    end else if (hitMem) begin
      sel = SEL_WB;
    end else if (hitWb) begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_match.sv
// ---------------------------------------------------------------------------
// fwd_match
//   Combinational comparison of one ID-stage source register against the
//   writer held in one pipeline stage. Register 0 is hard-wired to zero in
//   the register file, so a write to it is never a forwarding source.
//
//   Ports:
//     stage_wreg_i  stage instruction writes the register file
//     stage_wn_i    stage destination register index
//     src_i         ID-stage source register index
//     use_i         ID instruction actually reads this source
//     hit_o         the source depends on this stage's writer
// ---------------------------------------------------------------------------
module fwd_match
  import fwd_sel_ctrl_pkg::*;
(
  input  logic             stage_wreg_i,
  input  logic [REG_W-1:0] stage_wn_i,
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  output logic             hit_o
);

  assign hit_o = stage_wreg_i
              && (stage_wn_i != '0)
              && (stage_wn_i == src_i)
              && use_i;

endmodule

// File: rtl/fwd_sel_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_sel_ctrl
//   Forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
//   Tracks the destination registers of the instructions in EX, MEM and WB,
//   compares them with the ID-stage sources, and registers a select code for
//   each EX operand mux so it arrives together with the operand. A load in EX
//   feeding the ID instruction raises a combinational stall and a bubble is
//   pushed into EX in its place.
//
//   Ports:
//     clk_i          rising-edge clock
//     rst_i          synchronous, active-high reset
//     id_valid_i     ID stage holds a real instruction
//     id_rs_i        source register A index
//     id_rt_i        source register B index
//     id_use_rs_i    instruction reads rs
//     id_use_rt_i    instruction reads rt
//     id_wreg_i      instruction writes the register file
//     id_wn_i        destination register index
//     id_m2reg_i     instruction is a load
//     flush_i        squash the ID instruction (branch/jump redirect)
//     stall_o        load-use stall; freezes PC and IF/ID
//     ex_sel_a_o     operand-A mux select, valid in EX
//     ex_sel_b_o     operand-B mux select, valid in EX
// ---------------------------------------------------------------------------
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_wreg_i,
  input  logic [REG_W-1:0] id_wn_i,
  input  logic             id_m2reg_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [SEL_W-1:0] ex_sel_a_o,
  output logic [SEL_W-1:0] ex_sel_b_o
);

  stage_t exStage_q, exStage_d;
  stage_t memStage_q;
  stage_t wbStage_q;
  sel_t   selA_q, selA_d;
  sel_t   selB_q, selB_d;

  logic             stageWreg [NUM_STAGES];
  logic [REG_W-1:0] stageWn   [NUM_STAGES];
  logic             hitRs     [NUM_STAGES];
  logic             hitRt     [NUM_STAGES];
  logic             bubble;

  // The WB load flag never influences a decision: WB results reach the
  // consumer through register-file write-through regardless of their source.
  logic unusedWbLoad;
  assign unusedWbLoad = wbStage_q.m2reg;

  // Flatten the stage shadows so the comparators can be generated uniformly.
  assign stageWreg[ST_EX]  = exStage_q.wreg;
  assign stageWn[ST_EX]    = exStage_q.wn;
  assign stageWreg[ST_MEM] = memStage_q.wreg;
  assign stageWn[ST_MEM]   = memStage_q.wn;
  assign stageWreg[ST_WB]  = wbStage_q.wreg;
  assign stageWn[ST_WB]    = wbStage_q.wn;

  // One rs and one rt comparator per tracked stage.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    fwd_match uMatchRs (
      .stage_wreg_i (stageWreg[s]),
      .stage_wn_i   (stageWn[s]),
      .src_i        (id_rs_i),
      .use_i        (id_use_rs_i),
      .hit_o        (hitRs[s])
    );

    fwd_match uMatchRt (
      .stage_wreg_i (stageWreg[s]),
      .stage_wn_i   (stageWn[s]),
      .src_i        (id_rt_i),
      .use_i        (id_use_rt_i),
      .hit_o        (hitRt[s])
    );
  end

  // A load's data only exists at the end of MEM, so a consumer directly
  // behind it must wait one cycle. A flushed instruction is discarded anyway,
  // so it must not freeze the front end.
  assign stall_o = id_valid_i && !flush_i && exStage_q.m2reg
                && (hitRs[ST_EX] || hitRt[ST_EX]);

  // Next EX-stage shadow and operand selects. Anything that does not advance
  // into EX as a real instruction becomes a bubble with the register-file
  // select, so a stalled instruction is re-evaluated from scratch next cycle
  // when its load has moved on to MEM.
  always_comb begin
    bubble    = !id_valid_i || flush_i || stall_o;
    exStage_d = STAGE_BUBBLE;
    selA_d    = SEL_RF;
    selB_d    = SEL_RF;
    if (!bubble) begin
      exStage_d.wreg  = id_wreg_i;
      exStage_d.wn    = id_wn_i;
      exStage_d.m2reg = id_m2reg_i;
      selA_d = pickSel(hitRs[ST_EX], exStage_q.m2reg, hitRs[ST_MEM], hitRs[ST_WB]);
      selB_d = pickSel(hitRt[ST_EX], exStage_q.m2reg, hitRt[ST_MEM], hitRt[ST_WB]);
    end
  end

  // Stage shadows advance every cycle; only the EX entry can be a bubble.
  // Reset discards every tracked writer so nothing stale is forwarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exStage_q  <= STAGE_BUBBLE;
      memStage_q <= STAGE_BUBBLE;
      wbStage_q  <= STAGE_BUBBLE;
      selA_q     <= SEL_RF;
      selB_q     <= SEL_RF;
    end else begin
      exStage_q  <= exStage_d;
      memStage_q <= exStage_q;
      wbStage_q  <= memStage_q;
      selA_q     <= selA_d;
      selB_q     <= selB_d;
    end
  end

  assign ex_sel_a_o = selA_q;
  assign ex_sel_b_o = selB_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_sel_ctrl
//   Directed bench for fwd_sel_ctrl. Each ID-stage instruction is driven for
//   one clock; the combinational stall is sampled just before the edge and
//   the registered selects just after it, so the selects observed after an
//   instruction's edge belong to that instruction in EX.
// ---------------------------------------------------------------------------
module tb_fwd_sel_ctrl;
  import fwd_sel_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic [REG_W-1:0] id_wn;
  logic             id_m2reg;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] ex_sel_a;
  logic [SEL_W-1:0] ex_sel_b;

  int   errorCount = 0;
  int   checkCount = 0;
  logic lastStall;

  always #5 clk = ~clk;

  fwd_sel_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .id_valid_i  (id_valid),
    .id_rs_i     (id_rs),
    .id_rt_i     (id_rt),
    .id_use_rs_i (id_use_rs),
    .id_use_rt_i (id_use_rt),
    .id_wreg_i   (id_wreg),
    .id_wn_i     (id_wn),
    .id_m2reg_i  (id_m2reg),
    .flush_i     (flush),
    .stall_o     (stall),
    .ex_sel_a_o  (ex_sel_a),
    .ex_sel_b_o  (ex_sel_b)
  );

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one ID-stage instruction for a full clock, records the stall seen
  // before the edge and returns just after the edge.
  task automatic applyStimulus(input logic valid, input int rs, input int rt,
                               input logic useRs, input logic useRt,
                               input logic wreg, input int wn,
                               input logic m2reg, input logic flsh);
    id_valid  = valid;
    id_rs     = rs[REG_W-1:0];
    id_rt     = rt[REG_W-1:0];
    id_use_rs = useRs;
    id_use_rt = useRt;
    id_wreg   = wreg;
    id_wn     = wn[REG_W-1:0];
    id_m2reg  = m2reg;
    flush     = flsh;
    #1;
    lastStall = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic doNop();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic doAlu(input int wn, input int rs, input int rt);
    applyStimulus(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, wn, 1'b0, 1'b0);
  endtask

  task automatic doLoad(input int wn, input int base);
    applyStimulus(1'b1, base, wn, 1'b1, 1'b0, 1'b1, wn, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (3) doNop();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int r;
    int stalls;
    int guard;
    int totalStalls;
    totalStalls = 0;

    // Reset for two cycles while a writer of $3 sits on the ID inputs.
    rst       = 1'b1;
    id_valid  = 1'b1;
    id_rs     = 5'd1;
    id_rt     = 5'd2;
    id_use_rs = 1'b1;
    id_use_rt = 1'b1;
    id_wreg   = 1'b1;
    id_wn     = 5'd3;
    id_m2reg  = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetStall", int'(stall), 0);
    checkOutput("resetSelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("resetSelB", int'(ex_sel_b), int'(SEL_RF));
    rst = 1'b0;
    doAlu(20, 3, 3);
    checkOutput("staleSelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("staleSelB", int'(ex_sel_b), int'(SEL_RF));
    drain();

    // add $3 then sub reading rs=$3: forward from MEM.
    doAlu(3, 1, 2);
    doAlu(7, 3, 4);
    checkOutput("adjStall", int'(lastStall), 0);
    checkOutput("adjSelA", int'(ex_sel_a), int'(SEL_MEM));
    checkOutput("adjSelB", int'(ex_sel_b), int'(SEL_RF));
    drain();

    // add $3, nop, or reading rt=$3: forward from WB.
    doAlu(3, 1, 2);
    doNop();
    doAlu(8, 5, 3);
    checkOutput("gap1SelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("gap1SelB", int'(ex_sel_b), int'(SEL_WB));
    drain();

    // add $3, two nops, or reading rt=$3: register file write-through.
    doAlu(3, 1, 2);
    doNop();
    doNop();
    doAlu(8, 5, 3);
    checkOutput("gap2SelB", int'(ex_sel_b), int'(SEL_RF));
    drain();

    // Two writers of $3: the nearest one wins.
    doAlu(3, 1, 2);
    doAlu(3, 1, 2);
    doAlu(12, 3, 3);
    checkOutput("prioSelA", int'(ex_sel_a), int'(SEL_MEM));
    checkOutput("prioSelB", int'(ex_sel_b), int'(SEL_MEM));
    drain();

    // Operands forwarded from different stages at once.
    doAlu(3, 1, 2);
    doAlu(4, 1, 2);
    doAlu(13, 4, 3);
    checkOutput("mixSelA", int'(ex_sel_a), int'(SEL_MEM));
    checkOutput("mixSelB", int'(ex_sel_b), int'(SEL_WB));
    drain();

    // Matching indices but use bits clear: nothing forwarded.
    doAlu(3, 1, 2);
    applyStimulus(1'b1, 3, 3, 1'b0, 1'b0, 1'b1, 14, 1'b0, 1'b0);
    checkOutput("noUseSelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("noUseSelB", int'(ex_sel_b), int'(SEL_RF));
    doLoad(4, 1);
    applyStimulus(1'b1, 4, 2, 1'b0, 1'b1, 1'b1, 14, 1'b0, 1'b0);
    checkOutput("noUseStall", int'(lastStall), 0);
    drain();

    // lw $4 then add reading $4: one stall, then forward from WB.
    doLoad(4, 1);
    doAlu(9, 4, 2);
    checkOutput("luStall", int'(lastStall), 1);
    checkOutput("luBubbleSelA", int'(ex_sel_a), int'(SEL_RF));
    doAlu(9, 4, 2);
    checkOutput("luReStall", int'(lastStall), 0);
    checkOutput("luSelA", int'(ex_sel_a), int'(SEL_WB));
    checkOutput("luSelB", int'(ex_sel_b), int'(SEL_RF));
    drain();

    // Writers of $0 never forward or stall.
    doAlu(0, 1, 2);
    doAlu(15, 0, 0);
    checkOutput("r0SelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("r0SelB", int'(ex_sel_b), int'(SEL_RF));
    doLoad(0, 1);
    doAlu(15, 0, 0);
    checkOutput("r0LoadStall", int'(lastStall), 0);
    drain();

    // lw $5 then a flushed dependent writer of $6: no stall, bubble in EX.
    doLoad(5, 1);
    applyStimulus(1'b1, 5, 2, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b1);
    checkOutput("flushStall", int'(lastStall), 0);
    checkOutput("flushSelA", int'(ex_sel_a), int'(SEL_RF));
    doAlu(10, 6, 5);
    checkOutput("flushBubbleSelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("flushLoadSelB", int'(ex_sel_b), int'(SEL_WB));
    drain();

    // Reset mid-stream discards tracked writers.
    doAlu(3, 1, 2);
    rst = 1'b1;
    doNop();
    rst = 1'b0;
    doAlu(11, 3, 3);
    checkOutput("midRstSelA", int'(ex_sel_a), int'(SEL_RF));
    checkOutput("midRstSelB", int'(ex_sel_b), int'(SEL_RF));
    doLoad(7, 1);
    rst = 1'b1;
    doNop();
    rst = 1'b0;
    doAlu(11, 7, 2);
    checkOutput("midRstStall", int'(lastStall), 0);
    drain();

    // Back-to-back load / dependent-use pairs: exactly one stall each.
    for (int p = 0; p < 3; p++) begin
      r      = 16 + p;
      stalls = 0;
      guard  = 0;
      doLoad(r, 1);
      do begin
        doAlu(25, r, 2);
        if (lastStall) stalls++;
        guard++;
      end while (lastStall && guard < 4);
      checkOutput("pairStalls", stalls, 1);
      checkOutput("pairSelA", int'(ex_sel_a), int'(SEL_WB));
      totalStalls += stalls;
    end
    checkOutput("pairTotal", totalStalls, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
